// File: rtl/pattern_scanner_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scanner_pkg
// Shared constants for the serial bit-pattern detector family.
//   ps_state_e       : control FSM encoding (IDLE / SCAN / DONE)
//   cnt_width()      : width of bit-position and match-count fields for a
//                      scanned word of data_w bits (must hold 0..data_w)
//   DEFAULT_DATA_W   : default scanned word width
//   DEFAULT_PAT_W    : default pattern length
// -----------------------------------------------------------------------------
package pattern_scanner_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_PAT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } ps_state_e;

  // Needs to represent every value 0..data_w, so the all-ones "no match"
  // marker can never collide with a real bit index (0..data_w-1).
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage : pattern_scanner_pkg

// File: rtl/pattern_scanner_window.sv
// -----------------------------------------------------------------------------
// pattern_window
// PAT_W-bit shift window with a saturating fill counter and pattern compare.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   clear_i    : empty the window (launch of a new scan); wins over shift_i
//   shift_i    : consume bit_i this cycle
//   bit_i      : incoming serial bit, shifted in at the LSB
//   overlap_i  : 1 = keep the window full after a hit, 0 = restart filling
//   pattern_i  : target sequence, MSB is the oldest bit
//   hit_o      : combinational; the window after this shift matches
// -----------------------------------------------------------------------------
module pattern_window #(
  parameter int PAT_W = pattern_scanner_pkg::DEFAULT_PAT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic             overlap_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             hit_o
);

  localparam int                FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Post-shift view: the compare has to see the bit being consumed now.
  logic [PAT_W-1:0]  win_shift;
  logic [FILL_W-1:0] fill_post;

  assign win_shift = (win_q << 1) | PAT_W'(bit_i);
  assign fill_post = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
  assign hit_o     = shift_i && (fill_post == FULL) && (win_shift == pattern_i);

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clear_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_i) begin
      win_d = win_shift;
      // Without overlap the bits of a hit may not be reused, so the window
      // has to be refilled completely before the next hit is possible.
      fill_d = (hit_o && !overlap_i) ? '0 : fill_post;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule : pattern_window

// File: rtl/pattern_scanner.sv
// -----------------------------------------------------------------------------
// pattern_scanner
// Scans a captured DATA_W-bit word MSB first, one bit per clock, counting
// occurrences of a PAT_W-bit pattern.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : level; launches a scan when sampled high in IDLE or DONE
//   data       : word to scan (captured on the launch edge)
//   pattern    : target sequence, pattern[PAT_W-1] matched first (captured)
//   overlap    : 1 = overlapping matches counted (captured)
//   busy       : high while scanning
//   match      : one-cycle pulse per occurrence
//   match_cnt  : occurrences in the current/last scan
//   first_pos  : data bit index of the last bit of the first match,
//                all-ones when there was none
//   found      : sticky, any occurrence in the current/last scan
//   done       : one-cycle pulse on the first DONE cycle
//   dbg_state  : current control state
// Scan latency is DATA_W cycles from the launch edge; match for the last
// bit coincides with done.
// -----------------------------------------------------------------------------
module pattern_scanner
  import pattern_scanner_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int PAT_W  = DEFAULT_PAT_W,
  localparam int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              found,
  output logic              done,
  output ps_state_e         dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] MAX_MATCHES = CNT_W'(DATA_W - PAT_W + 1);

  ps_state_e         state_q;
  logic [DATA_W-1:0] data_q;
  logic [PAT_W-1:0]  pattern_q;
  logic              overlap_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  match_cnt_q;
  logic [CNT_W-1:0]  first_pos_q;
  logic              found_q;
  logic              busy_q;
  logic              match_q;
  logic              done_q;

  logic              launch;
  logic              scanning;
  logic              cur_bit;
  logic              hit;
  logic [DATA_W-1:0] data_shifted;

  assign launch   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign scanning = (state_q == ST_SCAN);

  // Shift instead of a variable part-select so the index width can differ
  // from the data width without truncation concerns.
  assign data_shifted = data_q >> idx_q;
  assign cur_bit      = data_shifted[0];

  pattern_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (launch),
    .shift_i   (scanning),
    .bit_i     (cur_bit),
    .overlap_i (overlap_q),
    .pattern_i (pattern_q),
    .hit_o     (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      pattern_q   <= '0;
      overlap_q   <= 1'b0;
      idx_q       <= '0;
      match_cnt_q <= '0;
      first_pos_q <= '1;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Pulses default low; only the SCAN branch raises them.
      match_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            data_q      <= data;
            pattern_q   <= pattern;
            overlap_q   <= overlap;
            idx_q       <= LAST_IDX;
            match_cnt_q <= '0;
            first_pos_q <= '1;
            found_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            match_q <= 1'b1;
            found_q <= 1'b1;
            if (match_cnt_q < MAX_MATCHES) begin
              match_cnt_q <= match_cnt_q + CNT_W'(1);
            end
            if (first_pos_q == '1) begin
              first_pos_q <= idx_q;
            end
          end
          if (idx_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign first_pos = first_pos_q;
  assign found     = found_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule : pattern_scanner

// File: tb/tb_pattern_scanner.sv
module tb_pattern_scanner;
  import pattern_scanner_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT (PAT_W=5)
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] pattern = '0;
  logic       overlap = 1'b0;
  logic       busy, match, found, done;
  logic [3:0] match_cnt, first_pos;
  ps_state_e  dbg_state;

  pattern_scanner #(.DATA_W(8), .PAT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .pattern   (pattern),
    .overlap   (overlap),
    .busy      (busy),
    .match     (match),
    .match_cnt (match_cnt),
    .first_pos (first_pos),
    .found     (found),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- DUT (PAT_W=8)
  logic       start8 = 1'b0;
  logic [7:0] data8 = '0;
  logic [7:0] pattern8 = '0;
  logic       overlap8 = 1'b0;
  logic       busy8, match8, found8, done8;
  logic [3:0] match_cnt8, first_pos8;
  ps_state_e  dbg_state8;

  pattern_scanner #(.DATA_W(8), .PAT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .data      (data8),
    .pattern   (pattern8),
    .overlap   (overlap8),
    .busy      (busy8),
    .match     (match8),
    .match_cnt (match_cnt8),
    .first_pos (first_pos8),
    .found     (found8),
    .done      (done8),
    .dbg_state (dbg_state8)
  );

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Launch in cycle T0 (start high before the edge ending T0), then sample
  // T1..T10 at negedges. Inputs are scrambled after capture to show the scan
  // only uses captured values. mmask bit t = expected match in cycle Tt.
  task automatic run_scan(input string name, input logic [7:0] d, input logic [4:0] p,
                          input logic ov, input logic [15:0] mmask, input int ecnt,
                          input int epos, input logic efound);
    @(negedge clk);
    start = 1'b1; data = d; pattern = p; overlap = ov;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) begin
        start = 1'b0; data = ~d; pattern = ~p; overlap = ~ov;
      end
      check_val({name, "_match"}, 32'(match), 32'(mmask[t]));
      check_val({name, "_done"},  32'(done),  32'(t == 9));
      check_val({name, "_busy"},  32'(busy),  32'(t <= 8));
    end
    check_val({name, "_cnt"},   32'(match_cnt), 32'(ecnt));
    check_val({name, "_pos"},   32'(first_pos), 32'(epos));
    check_val({name, "_found"}, 32'(found),     32'(efound));
    check_val({name, "_state"}, 32'(dbg_state), 32'(ST_DONE));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset state
    @(negedge clk);
    check_val("rst_busy",  32'(busy),      32'd0);
    check_val("rst_match", 32'(match),     32'd0);
    check_val("rst_done",  32'(done),      32'd0);
    check_val("rst_found", 32'(found),     32'd0);
    check_val("rst_cnt",   32'(match_cnt), 32'd0);
    check_val("rst_pos",   32'(first_pos), 32'hF);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_no_start", 32'(dbg_state), 32'(ST_IDLE));

    // Directed vectors, pattern 10010
    run_scan("ovl1",    8'b10010010, 5'b10010, 1'b1, 16'h0240, 2, 3, 1'b1);
    run_scan("ovl0",    8'b10010010, 5'b10010, 1'b0, 16'h0040, 1, 3, 1'b1);
    run_scan("nomatch", 8'b01101101, 5'b10010, 1'b1, 16'h0000, 0, 15, 1'b0);
    // All-zero word: maximum possible count with overlap, one without
    run_scan("zero_ov1", 8'h00, 5'b00000, 1'b1, 16'h03C0, 4, 3, 1'b1);
    run_scan("zero_ov0", 8'h00, 5'b00000, 1'b0, 16'h0040, 1, 3, 1'b1);

    // Results hold in DONE without a start
    repeat (3) @(negedge clk);
    check_val("hold_cnt",   32'(match_cnt), 32'd1);
    check_val("hold_found", 32'(found),     32'd1);
    check_val("hold_done",  32'(done),      32'd0);

    // Asynchronous reset mid-scan at T4
    @(negedge clk);
    start = 1'b1; data = 8'b10010010; pattern = 5'b10010; overlap = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("arst_busy",  32'(busy),      32'd0);
    check_val("arst_cnt",   32'(match_cnt), 32'd0);
    check_val("arst_pos",   32'(first_pos), 32'hF);
    check_val("arst_found", 32'(found),     32'd0);
    check_val("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_val("post_rst_busy", 32'(busy),      32'd0);
    run_scan("after_rst", 8'b10010010, 5'b10010, 1'b1, 16'h0240, 2, 3, 1'b1);

    // start held high through SCAN, inputs changed at T3
    @(negedge clk);
    start = 1'b1; data = 8'b10010010; pattern = 5'b10010; overlap = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (t == 3) begin
        data = 8'h00; pattern = 5'b00000; overlap = 1'b0;
      end
      check_val("held_match", 32'(match), 32'((t == 6) || (t == 9)));
      check_val("held_done",  32'(done),  32'(t == 9));
    end
    check_val("held_cnt",   32'(match_cnt), 32'd2);
    check_val("held_pos",   32'(first_pos), 32'd3);
    check_val("held_found", 32'(found),     32'd1);
    @(negedge clk);
    check_val("relaunch_busy",  32'(busy),      32'd1);
    check_val("relaunch_state", 32'(dbg_state), 32'(ST_SCAN));
    check_val("relaunch_cnt",   32'(match_cnt), 32'd0);
    check_val("relaunch_pos",   32'(first_pos), 32'hF);
    check_val("relaunch_found", 32'(found),     32'd0);
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_val("relaunch_done_seen", 32'(done), 32'd1);
      check_val("relaunch_latency",   32'(k),    32'd8);
    end
    check_val("relaunch_res_cnt", 32'(match_cnt), 32'd1);
    check_val("relaunch_res_pos", 32'(first_pos), 32'd3);

    // PAT_W = DATA_W: single match on the last bit, same cycle as done
    @(negedge clk);
    start8 = 1'b1; data8 = 8'hA5; pattern8 = 8'hA5; overlap8 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start8 = 1'b0; data8 = 8'h00;
      check_val("full_match", 32'(match8), 32'(t == 9));
      check_val("full_done",  32'(done8),  32'(t == 9));
      if (t == 9) begin
        check_val("full_cnt",   32'(match_cnt8), 32'd1);
        check_val("full_pos",   32'(first_pos8), 32'd0);
        check_val("full_found", 32'(found8),     32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pattern_scanner

// File: doc/pattern_scanner.md
PATTERN_SCANNER -- requirements
Module: pattern_scanner

Interface
REQ-001 Parameter DATA_W, default 8: width of the scanned input word; legal range 2..32.
REQ-002 Parameter PAT_W, default 5: pattern length in bits; legal range 1..DATA_W.
REQ-003 Derived constant CNT_W = clog2(DATA_W+1): width of the counter and position fields.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port start, input, 1: level sampled each clock; when high in IDLE or DONE, launches a scan.
REQ-007 Port data, input, DATA_W: word to scan, MSB first.
REQ-008 Port pattern, input, PAT_W: target sequence; pattern[PAT_W-1] is matched first.
REQ-009 Port overlap, input, 1: 1 = overlapping matches allowed; 0 = window restarts after each match.
REQ-010 Port busy, output, 1: high while in SCAN.
REQ-011 Port match, output, 1: one-cycle pulse per detected occurrence.
REQ-012 Port match_cnt, output, CNT_W: number of matches in the current/last scan.
REQ-013 Port first_pos, output, CNT_W: bit index in data of the last bit of the first match; all-ones if none.
REQ-014 Port found, output, 1: sticky flag (LED drive), high once any match occurs in the current/last scan.
REQ-015 Port done, output, 1: one-cycle pulse marking scan completion.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-017 In IDLE or DONE with start=1, the block SHALL on that edge capture data, pattern and overlap into internal registers, set idx=DATA_W-1, clear window fill, match_cnt and found, set first_pos to all-ones, and enter SCAN.
REQ-018 Each SCAN cycle SHALL consume captured bit data_q[idx], shift it into a PAT_W-bit window (LSB in) and increment fill, saturating at PAT_W.
REQ-019 A match SHALL be declared when the post-shift fill equals PAT_W and the post-shift window equals pattern_q; match SHALL be high in the cycle after the completing bit is consumed.
REQ-020 On a match: match_cnt SHALL increment, found SHALL set, and first_pos SHALL be set to idx only if it is still all-ones.
REQ-021 On a match with overlap_q=0, fill SHALL be cleared on the same edge; with overlap_q=1, fill SHALL remain PAT_W.
REQ-022 When the bit at idx=0 is consumed, the FSM SHALL enter DONE and done SHALL be high during the first DONE cycle only; scan latency is DATA_W cycles from the start edge.
REQ-023 A match on the final bit SHALL pulse match and done in the same cycle.
REQ-024 start during SCAN SHALL be ignored; input changes during SCAN SHALL not affect the scan.
REQ-025 In DONE, match_cnt, first_pos and found SHALL hold until the next accepted start.
REQ-026 match_cnt SHALL never exceed DATA_W-PAT_W+1 and SHALL not wrap.

Reset
REQ-027 When rst=0 the block SHALL immediately enter IDLE with busy, match, done and found at 0, match_cnt at 0, first_pos all-ones, and all internal registers cleared, including mid-scan.
REQ-028 After rst returns high, the first scan SHALL begin only on a start sampled high.

Structure
REQ-029 The state encodings and the CNT_W derivation SHALL live in the team's shared constants header, reused by future detector blocks.
REQ-030 The window shift register, together with its fill counter and comparator, SHALL be a sub-module named pattern_window, parameterised by PAT_W.

Verification (DATA_W=8, PAT_W=5, pattern=5'b10010)
REQ-031 data=8'b10010010, overlap=1, start at T0 -> match in T6 and T9, done in T9, match_cnt=2, first_pos=3, found=1.
REQ-032 Same data, overlap=0 -> a single match in T6, match_cnt=1, first_pos=3, done in T9.
REQ-033 data=8'b01101101 -> no match, match_cnt=0, first_pos=8'hFF truncated to CNT_W (all-ones), found=0, done in T9.
REQ-034 rst driven low at T4 of a scan -> outputs reach their reset values without waiting for a clock; a later start gives a clean, full result.
REQ-035 start held high through SCAN with data changed at T3 -> result reflects the T0 capture, and a new scan starts at the DONE cycle.
REQ-036 PAT_W=8, pattern=data=8'hA5 -> a single match with done in the same cycle, first_pos=0.
